// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: ROM read port, redirect request and the decode handshake.
//   master : fetch_queue side (drives ROM read and decode outputs)
//   slave  : environment side (ROM, branch resolution, decode)
interface fetch_queue_if #(
  parameter int unsigned ROM_AWIDTH = 8,
  parameter int unsigned IWIDTH     = 16,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                  rom_rd;
  logic [ROM_AWIDTH-1:0] rom_raddr;
  logic [IWIDTH-1:0]     rom_rdata;
  logic                  redirect;
  logic [ROM_AWIDTH-1:0] redirect_pc;
  logic                  o_valid;
  logic [IWIDTH-1:0]     o_instr;
  logic [ROM_AWIDTH-1:0] o_pc;
  logic                  i_ready;
  logic [CW-1:0]         o_count;

  modport master (
    output rom_rd, rom_raddr, o_valid, o_instr, o_pc, o_count,
    input  rom_rdata, redirect, redirect_pc, i_ready
  );

  modport slave (
    input  rom_rd, rom_raddr, o_valid, o_instr, o_pc, o_count,
    output rom_rdata, redirect, redirect_pc, i_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues synchronous ROM reads,
// buffers returned words with their PCs in a small FIFO and hands them to
// decode over valid/ready. A redirect flushes queued and in-flight fetches.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fetch_queue_if.master (ROM read port, redirect, decode handshake,
//          o_count occupancy)
// Build option: define FETCH_BYPASS_EN to forward a live ROM response straight
// to decode when the FIFO is empty (saves one cycle of latency).
module fetch_queue #(
  parameter int unsigned ROM_AWIDTH = 8,
  parameter int unsigned IWIDTH     = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ROM_AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [ROM_AWIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  killed_q, killed_d;
  logic [IWIDTH-1:0]     instr_mem_q [DEPTH];
  logic [IWIDTH-1:0]     instr_mem_d [DEPTH];
  logic [ROM_AWIDTH-1:0] pc_mem_q [DEPTH];
  logic [ROM_AWIDTH-1:0] pc_mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic issue_c, live_c, fifo_valid_c, bypass_c, push_c, pop_c;

  // Issue credit, handshake qualifiers and decode-facing outputs.
  always_comb begin
    live_c       = inflight_q & ~killed_q;
    fifo_valid_c = (count_q != '0);
    // Queued plus in-flight words never exceed DEPTH, so a push always fits.
    issue_c      = ~rst & ~bus.redirect &
                   (({1'b0, count_q} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH));
    bus.rom_rd    = issue_c;
    bus.rom_raddr = fetch_pc_q;
    bus.o_count   = count_q;
`ifdef FETCH_BYPASS_EN
    bypass_c    = ~fifo_valid_c & live_c & ~bus.redirect;
    bus.o_valid = fifo_valid_c | bypass_c;
    bus.o_instr = fifo_valid_c ? instr_mem_q[rd_ptr_q] :
                  (bypass_c ? bus.rom_rdata : '0);
    bus.o_pc    = fifo_valid_c ? pc_mem_q[rd_ptr_q] :
                  (bypass_c ? inflight_pc_q : '0);
`else
    bypass_c    = 1'b0;
    bus.o_valid = fifo_valid_c;
    bus.o_instr = fifo_valid_c ? instr_mem_q[rd_ptr_q] : '0;
    bus.o_pc    = fifo_valid_c ? pc_mem_q[rd_ptr_q] : '0;
`endif
    // A bypassed word taken by decode is never written into the FIFO.
    push_c = live_c & ~bus.redirect & ~(bypass_c & bus.i_ready);
    pop_c  = fifo_valid_c & bus.i_ready & ~bus.redirect;
  end

  // Next-state: reset, then redirect flush, then normal issue/push/pop.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue_c;
    inflight_pc_d = fetch_pc_q;
    killed_d      = 1'b0;
    instr_mem_d   = instr_mem_q;
    pc_mem_d      = pc_mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (rst) begin
      fetch_pc_d    = '0;
      inflight_d    = 1'b0;
      inflight_pc_d = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_d[i] = '0;
        pc_mem_d[i]    = '0;
      end
    end else if (bus.redirect) begin
      // Whatever response is still outstanding belongs to the old stream.
      fetch_pc_d = bus.redirect_pc;
      killed_d   = 1'b1;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue_c) begin
        fetch_pc_d = fetch_pc_q + ROM_AWIDTH'(1);
      end
      if (push_c) begin
        instr_mem_d[wr_ptr_q] = bus.rom_rdata;
        pc_mem_d[wr_ptr_q]    = inflight_pc_q;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    fetch_pc_q    <= fetch_pc_d;
    inflight_q    <= inflight_d;
    inflight_pc_q <= inflight_pc_d;
    killed_q      <= killed_d;
    instr_mem_q   <= instr_mem_d;
    pc_mem_q      <= pc_mem_d;
    wr_ptr_q      <= wr_ptr_d;
    rd_ptr_q      <= rd_ptr_d;
    count_q       <= count_d;
  end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int unsigned AW    = 8;
  localparam int unsigned IW    = 16;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.ROM_AWIDTH(AW), .IWIDTH(IW), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.ROM_AWIDTH(AW), .IWIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous ROM, ROM[k] = 0x1000 + k; junk when no read was issued.
  always @(posedge clk) begin
    if (bus.rom_rd === 1'b1) bus.rom_rdata <= 16'h1000 + IW'(bus.rom_raddr);
    else                     bus.rom_rdata <= 16'hDEAD;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: fetch PC, queue of buffered PCs, one outstanding read.
  int m_pc      = 0;
  int m_q[$];
  bit m_pend    = 1'b0;
  int m_pend_pc = 0;

  // Values observed in the most recent step.
  logic          s_valid, s_rd, s_deliv;
  logic [IW-1:0] s_instr;
  logic [AW-1:0] s_pc, s_raddr;
  logic [2:0]    s_count;

  int got_pc[8];
  int got_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model mid-cycle, advance model.
  task automatic step(input bit r, input bit rdy, input bit redir, input logic [AW-1:0] rpc);
    int sz;
    bit e_rd, byp, e_valid;
    int e_pc, e_instr;
    rst             = r;
    bus.i_ready     = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    @(negedge clk);
    sz   = m_q.size();
    e_rd = !r && !redir && ((sz + int'(m_pend)) < int'(DEPTH));
    byp  = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp  = (sz == 0) && m_pend && !redir;
`endif
    e_valid = (sz > 0) || byp;
    e_pc    = (sz > 0) ? m_q[0] : (byp ? m_pend_pc : 0);
    e_instr = e_valid ? (32'h1000 + e_pc) : 0;
    check("rom_rd", 32'(bus.rom_rd), 32'(e_rd));
    if (e_rd) check("rom_raddr", 32'(bus.rom_raddr), 32'(m_pc));
    check("o_valid", 32'(bus.o_valid), 32'(e_valid));
    check("o_instr", 32'(bus.o_instr), 32'(e_instr));
    check("o_pc",    32'(bus.o_pc),    32'(e_pc));
    check("o_count", 32'(bus.o_count), 32'(sz));
    s_valid = bus.o_valid;
    s_instr = bus.o_instr;
    s_pc    = bus.o_pc;
    s_count = bus.o_count;
    s_rd    = bus.rom_rd;
    s_raddr = bus.rom_raddr;
    s_deliv = (bus.o_valid === 1'b1) && rdy && !redir && !r;
    if (r) begin
      m_q.delete();
      m_pc   = 0;
      m_pend = 1'b0;
    end else if (redir) begin
      m_q.delete();
      m_pc   = int'(rpc);
      m_pend = 1'b0;
    end else begin
      if (!(byp && rdy)) begin
        if (sz > 0 && rdy) void'(m_q.pop_front());
        if (m_pend) m_q.push_back(m_pend_pc);
      end
      m_pend    = e_rd;
      m_pend_pc = m_pc;
      if (e_rd) m_pc = (m_pc + 1) % 256;
    end
    @(posedge clk);
    #1;
  endtask

  // Run with i_ready=1 until n words are delivered or the budget runs out.
  task automatic collect(input int n, input int budget);
    got_n = 0;
    for (int i = 0; i < 8; i++) got_pc[i] = -1;
    for (int c = 0; c < budget && got_n < n; c++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      if (s_deliv && got_n < 8) begin
        got_pc[got_n] = int'(s_pc);
        got_n++;
      end
    end
  endtask

  initial begin
    int first_v, exp_first, nexp;
    rst             = 1'b1;
    bus.i_ready     = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    step(1'b1, 1'b1, 1'b0, '0);

    // Streaming from reset with decode always ready.
`ifdef FETCH_BYPASS_EN
    exp_first = 1;
`else
    exp_first = 2;
`endif
    first_v = -1;
    nexp    = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      if (s_valid === 1'b1 && first_v < 0) first_v = i;
      if (s_deliv) begin
        check("t1_stream_pc", 32'(s_pc), 32'(nexp));
        nexp++;
      end
    end
    check("t1_first_valid", 32'(first_v), 32'(exp_first));

    // Back-pressure: FIFO fills to DEPTH and issue stops.
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, '0);
    check("t2_count_full", 32'(s_count), 32'(DEPTH));
    check("t2_rd_stalled", 32'(s_rd), 32'd0);
    collect(4, 8);
    for (int i = 0; i < 4; i++) check("t2_release_pc", 32'(got_pc[i]), 32'(i));

    // Redirect with queued words and a read in flight.
    for (int i = 0; i < 10 && !(m_q.size() == 3 && m_pend); i++) step(1'b0, 1'b0, 1'b0, '0);
    check("t3_setup_inflight", 32'(m_pend), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h40);
    step(1'b0, 1'b1, 1'b0, '0);
    check("t3_bubble_valid", 32'(s_valid), 32'd0);
    check("t3_bubble_instr", 32'(s_instr), 32'd0);
    collect(1, 8);
    check("t3_first_pc", 32'(got_pc[0]), 32'h40);

    // PC wrap.
    step(1'b0, 1'b1, 1'b1, 8'hFE);
    collect(4, 10);
    check("t4_wrap_pc0", 32'(got_pc[0]), 32'hFE);
    check("t4_wrap_pc1", 32'(got_pc[1]), 32'hFF);
    check("t4_wrap_pc2", 32'(got_pc[2]), 32'h00);
    check("t4_wrap_pc3", 32'(got_pc[3]), 32'h01);

    // Back-to-back redirects: last one wins.
    step(1'b0, 1'b1, 1'b1, 8'h10);
    step(1'b0, 1'b1, 1'b1, 8'h20);
    collect(1, 8);
    check("t5_first_pc", 32'(got_pc[0]), 32'h20);

    // Mid-stream reset with three words queued.
    for (int i = 0; i < 10 && m_q.size() != 3; i++) step(1'b0, 1'b0, 1'b0, '0);
    check("t6_setup_count", 32'(m_q.size()), 32'd3);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("t6_valid",  32'(s_valid), 32'd0);
    check("t6_instr",  32'(s_instr), 32'd0);
    check("t6_pc",     32'(s_pc),    32'd0);
    check("t6_count",  32'(s_count), 32'd0);
    check("t6_rd",     32'(s_rd),    32'd1);
    check("t6_raddr",  32'(s_raddr), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0),
           AW'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
